// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Definitions shared between the elastic FIFO and its drain
//               controller: default widths and the skid occupancy encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default data word width, matching the FIFO data_out width
  localparam int DEF_WIDTH     = 8;
  // Default width of each statistics counter
  localparam int DEF_CNT_WIDTH = 16;

  // Skid occupancy; three bits cover every legal depth (2..4)
  typedef logic [2:0] occ_t;

  // Occupancy state encoding; the encoding equals the number of held words
  localparam occ_t OCC_EMPTY = 3'd0;
  localparam occ_t OCC_ONE   = 3'd1;
  localparam occ_t OCC_TWO   = 3'd2;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf
// Description : Circular skid buffer holding words returned by the FIFO until
//               the downstream stage accepts them. Head entry is the output.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output occ_t             occ,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  occ_t             occ_q, occ_d;
  logic             w_capture;
  logic             w_pop;

  // Pointers wrap at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A flush drops the arriving word; pop is ignored when nothing is held
  always_comb begin
    w_capture = push && !flush;
    w_pop     = pop && (occ_q != OCC_EMPTY);
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (w_capture) begin
        mem_d[tail_q] = push_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (w_pop) begin
        head_d = ptr_inc(head_q);
      end
    end
  end

  if (DEPTH == 2) begin : g_fsm2
    // Two-entry occupancy FSM: EMPTY <-> ONE <-> TWO
    always_comb begin
      occ_d = occ_q;
      if (flush) begin
        occ_d = OCC_EMPTY;
      end else begin
        case (occ_q)
          OCC_EMPTY: if (w_capture) occ_d = OCC_ONE;
          OCC_ONE: begin
            if (w_pop && !w_capture)      occ_d = OCC_EMPTY;
            else if (w_capture && !w_pop) occ_d = OCC_TWO;
          end
          OCC_TWO:   if (w_pop && !w_capture) occ_d = OCC_ONE;
          default:   occ_d = OCC_EMPTY;
        endcase
      end
    end
  end else begin : g_cnt
    // Deeper buffers track occupancy as a plain up/down count
    always_comb begin
      occ_d = occ_q;
      if (flush) occ_d = OCC_EMPTY;
      else       occ_d = occ_q + occ_t'(w_capture) - occ_t'(w_pop);
    end
  end

  // Storage, pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= OCC_EMPTY;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[head_q];

  // The read credit must never let a word arrive into a full buffer
  ap_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_capture && !w_pop && (occ_q == occ_t'(DEPTH))));

endmodule : skid_buf
`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain_ctrl
// Description : Drains the elastic FIFO into a valid/ready stream. Reads are
//               issued only against guaranteed skid space; keeps read,
//               transfer and stall statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  occ_t                 w_occ;
  logic                 w_pop;
  logic                 w_rd_accept;
  logic                 w_credit_ok;
  logic [3:0]           w_used;
  logic [3:0]           w_avail;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  assign m_valid = (w_occ != OCC_EMPTY);
  assign w_pop   = m_valid && m_ready;

  // Credit > 0 rewritten as occ + inflight < depth + pop to stay unsigned
  always_comb begin
    w_used      = {1'b0, w_occ} + 4'(inflight_q);
    w_avail     = 4'(SKID_DEPTH) + 4'(w_pop);
    w_credit_ok = (w_used < w_avail);
    fifo_rd_en  = !rst && !flush && !fifo_empty && w_credit_ok;
    w_rd_accept = fifo_rd_en && !fifo_empty;
  end

  // Next-state for the in-flight marker and the statistics counters
  always_comb begin
    inflight_d    = w_rd_accept;
    rd_count_d    = rd_count_q;
    xfer_count_d  = xfer_count_q;
    stall_count_d = stall_count_q;
    if (w_rd_accept) rd_count_d = rd_count_q + 1'b1;
    if (w_pop)       xfer_count_d = xfer_count_q + 1'b1;
    if (m_valid && !m_ready && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Control and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      rd_count_q    <= '0;
      xfer_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      inflight_q    <= inflight_d;
      rd_count_q    <= rd_count_d;
      xfer_count_q  <= xfer_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_data),
    .pop       (w_pop),
    .flush     (flush),
    .occ       (w_occ),
    .head_data (m_data)
  );

  assign rd_count    = rd_count_q;
  assign xfer_count  = xfer_count_q;
  assign stall_count = stall_count_q;

endmodule : fifo_drain_ctrl
`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain_ctrl
// Description : Self-checking bench for fifo_drain_ctrl with a behavioural
//               FIFO and a scoreboard of expected stream words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain_ctrl;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [W-1:0]  fifo_data;
  logic          fifo_rd_en;
  logic          flush;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] rd_count, xfer_count, stall_count;

  logic          rst_s;
  logic          s_rd_en, s_valid;
  logic [W-1:0]  s_data;
  logic [3:0]    s_rd, s_xfer, s_stall;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.WIDTH(W), .SKID_DEPTH(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .rd_count(rd_count), .xfer_count(xfer_count),
    .stall_count(stall_count)
  );

  // Narrow-counter instance, always fed and never drained
  fifo_drain_ctrl #(.WIDTH(W), .SKID_DEPTH(2), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst_s), .fifo_empty(1'b0), .fifo_data(8'hA5),
    .fifo_rd_en(s_rd_en), .flush(1'b0), .m_data(s_data), .m_valid(s_valid),
    .m_ready(1'b0), .rd_count(s_rd), .xfer_count(s_xfer), .stall_count(s_stall)
  );

  int            n_vec = 0;
  int            n_bad = 0;
  logic [W-1:0]  fq[$];
  logic [W-1:0]  exp_q[$];
  int            rd_seen = 0;
  int            cyc = 0;
  int            first_rd = -1;
  int            first_v = -1;
  int            rd0;
  logic [CW-1:0] exp_stall = '0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic load(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: monitor at negedge, FIFO model and reference counts at posedge
  task automatic tick();
    logic rd;
    @(negedge clk);
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_xfer", 32'd1, 32'd0);
        else                   chk("xfer_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      chk("stall_count", 32'(stall_count), 32'(exp_stall));
    end
    prev_stall = !rst && !flush && m_valid && !m_ready;
    prev_data  = m_data;
    if (first_rd < 0 && fifo_rd_en) first_rd = cyc;
    if (first_v < 0 && m_valid)     first_v = cyc;
    @(posedge clk);
    rd = fifo_rd_en && !fifo_empty;
    if (rst) begin
      rd_seen   = 0;
      exp_stall = '0;
    end else begin
      if (rd) rd_seen++;
      if (m_valid && !m_ready && exp_stall != '1) exp_stall = exp_stall + 1'b1;
    end
    cyc++;
    #1;
    if (rd) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    if (rst || flush) exp_q = fq;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst_s = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0;
    tick(); tick();
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    rst = 1'b0;

    // Streaming with ready held high
    m_ready = 1'b1;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    for (int i = 0; i < 20 && first_v < 0; i++) tick();
    repeat (3) tick();
    chk("latency", 32'(first_v - first_rd), 32'd2);
    chk("burst_xfer", 32'(xfer_count), 32'd4);
    chk("burst_rd", 32'(rd_count), 32'd4);

    // Downstream stalled: only two reads may be accepted
    m_ready = 1'b0;
    rd0 = rd_seen;
    load(8'h55); load(8'h66); load(8'h77); load(8'h88); load(8'h99);
    repeat (6) tick();
    chk("stall_reads", 32'(rd_seen - rd0), 32'd2);
    chk("stall_head", 32'(m_data), 32'h55);
    chk("stall_cnt4", 32'(stall_count), 32'd4);
    chk("stall_rd_en", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    drain();
    tick();
    chk("stall_rd_total", 32'(rd_count), 32'd9);
    chk("stall_xfer_total", 32'(xfer_count), 32'd9);

    // Ready toggling while streaming eight words
    for (int i = 0; i < 8; i++) load(8'hA0 + 8'(i));
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    drain();
    tick();
    chk("toggle_xfer", 32'(xfer_count), 32'd17);
    chk("toggle_rd", 32'(rd_count), 32'd17);

    // Flush with one word held and one in flight, while a pop happens
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(8'hB0 + 8'(i));
    tick(); tick();
    m_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_rd_en", 32'(fifo_rd_en), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(m_valid), 32'd0);
    drain();
    tick();
    chk("flush_rd", 32'(rd_count), 32'd23);
    chk("flush_xfer", 32'(xfer_count), 32'd22);
    chk("flush_rd_model", 32'(rd_count), 32'(rd_seen));

    // Reset asserted while a read is in flight
    m_ready = 1'b0;
    load(8'hC0); load(8'hC1); load(8'hC2); load(8'hC3);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_rd", 32'(rd_count), 32'd0);
    chk("mid_rst_xfer", 32'(xfer_count), 32'd0);
    chk("mid_rst_stall", 32'(stall_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    drain();
    tick();
    chk("post_rst_rd", 32'(rd_count), 32'd3);
    chk("post_rst_xfer", 32'(xfer_count), 32'd3);

    // Stall counter saturation on the 4-bit instance
    rst_s = 1'b0;
    repeat (21) tick();
    chk("sat_valid", 32'(s_valid), 32'd1);
    chk("sat_data", 32'(s_data), 32'hA5);
    chk("sat_stall", 32'(s_stall), 32'hF);
    chk("sat_rd", 32'(s_rd), 32'd2);
    chk("sat_xfer", 32'(s_xfer), 32'd0);
    chk("sat_rd_en", 32'(s_rd_en), 32'd0);
    repeat (3) tick();
    chk("sat_hold", 32'(s_stall), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_fifo_drain_ctrl
`default_nettype wire
